// File: rtl/tft_pkg.sv
// tft_pkg: shared types and constants for the TFT init sequencer.
package tft_pkg;
    localparam int ENTRY_W = 10;
    localparam logic [7:0] HWRST_MS = 8'd10;
    localparam logic [7:0] POSTRST_MS = 8'd120;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HWRST   = 3'd1,
        S_FETCH   = 3'd2,
        S_SEND    = 3'd3,
        S_DELAY   = 3'd4,
        S_DONE    = 3'd5,
        S_POSTRST = 3'd6
    } state_e;
    typedef enum logic [1:0] {
        T_CMD   = 2'b00,
        T_DATA  = 2'b01,
        T_DELAY = 2'b10,
        T_END   = 2'b11
    } entry_e;
    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction
endpackage

// File: rtl/tft_init_rom.sv
// tft_init_rom: combinational init table, {type[1:0], payload[7:0]} per entry.
// FILL_CMD swaps in a table of CMD entries (payload = index) with no END.
module tft_init_rom
    import tft_pkg::*;
#(
    parameter int AW       = 5,
    parameter bit FILL_CMD = 1'b0
) (
    input  logic [AW-1:0]      idx_i,
    output logic [ENTRY_W-1:0] entry_o
);
    always_comb begin
        entry_o = {T_END, 8'h00};
        if (FILL_CMD) entry_o = {T_CMD, 8'(idx_i)};
        else
            case (int'(idx_i))
                0: entry_o = {T_CMD, 8'h11};
                1: entry_o = {T_DELAY, 8'h02};
                2: entry_o = {T_CMD, 8'h29};
                3: entry_o = {T_DATA, 8'hA5};
                default: entry_o = {T_END, 8'h00};
            endcase
    end
endmodule

// File: rtl/tft_init_sequencer.sv
// tft_init_sequencer: walks the init table and feeds bytes to a byte shifter.
// Define TFT_HW_RESET_EN to add the 10 ms / 120 ms panel hardware-reset phase.
module tft_init_sequencer
    import tft_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int ROM_DEPTH = 32,
    parameter bit FILL_CMD  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    output logic       tft_rst_n,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);
    localparam int AW = ROM_DEPTH > 1 ? $clog2(ROM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(ROM_DEPTH - 1);
    localparam logic [31:0] DIV_M1 = 32'(ms_div(CLK_HZ) - 1);
`ifdef TFT_HW_RESET_EN
    localparam state_e START_ST = S_HWRST;
`else
    localparam state_e START_ST = S_FETCH;
`endif
    state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0] data_q, data_d, ms_q, ms_d, ms_tgt;
    logic dc_q, dc_d, tick, tdone, adv;
    logic [31:0] presc_q, presc_d;
    logic [ENTRY_W-1:0] entry;
    entry_e etype;
    tft_init_rom #(.AW(AW), .FILL_CMD(FILL_CMD)) u_rom (.idx_i(idx_q), .entry_o(entry));
    assign etype  = entry_e'(entry[9:8]);
    assign tick   = presc_q == DIV_M1;
    assign ms_tgt = state_q == S_HWRST ? HWRST_MS : state_q == S_POSTRST ? POSTRST_MS : data_q;
    assign tdone  = tick && (ms_q + 8'd1 == ms_tgt);
    // A zero-length delay leaves after its single cycle without waiting for a tick.
    assign adv    = state_q == S_SEND ? tx_ready : (data_q == 8'd0 || tdone);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dc_d    = dc_q;
        presc_d = tick ? '0 : presc_q + 32'd1;
        ms_d    = tick ? ms_q + 8'd1 : ms_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                idx_d   = '0;
                presc_d = '0;
                ms_d    = '0;
                state_d = START_ST;
            end
            S_HWRST: if (tdone) begin
                presc_d = '0;
                ms_d    = '0;
                state_d = S_POSTRST;
            end
            S_POSTRST: if (tdone) state_d = S_FETCH;
            S_FETCH: begin
                data_d  = entry[7:0];
                dc_d    = entry[8];
                presc_d = '0;
                ms_d    = '0;
                state_d = etype == T_END ? S_DONE : etype == T_DELAY ? S_DELAY : S_SEND;
            end
            // The last slot ends the run instead of wrapping the index.
            S_SEND, S_DELAY: if (adv) begin
                idx_d   = idx_q == LAST ? idx_q : idx_q + AW'(1);
                state_d = idx_q == LAST ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            dc_q    <= 1'b0;
            presc_q <= '0;
            ms_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
        end
    end
    assign tx_valid = state_q == S_SEND;
    assign tx_data  = data_q;
    assign tx_dc    = dc_q;
    assign busy     = !(state_q == S_IDLE || state_q == S_DONE);
    assign done     = state_q == S_DONE;
    assign state    = state_q;
`ifdef TFT_HW_RESET_EN
    assign tft_rst_n = state_q != S_HWRST;
`else
    assign tft_rst_n = 1'b1;
`endif
endmodule

// File: doc/tft_init_sequencer.md
TFT_INIT_SEQUENCER -- requirements
Module: tft_init_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000: clk frequency, used to derive the 1 ms tick.
REQ-002 SHALL have parameter ROM_DEPTH, default 32: number of init-table entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to run the init sequence.
REQ-006 SHALL have port tx_ready, input, 1 bit: the byte shifter can accept a byte.
REQ-007 SHALL have port tx_valid, output, 1 bit: tx_data and tx_dc are valid.
REQ-008 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-009 SHALL have port tx_dc, output, 1 bit: 0 = command byte, 1 = parameter byte.
REQ-010 SHALL have port tft_rst_n, output, 1 bit: panel hardware reset, active-low.
REQ-011 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-012 SHALL have port done, output, 1 bit: the sequence completed; held until the next start.
REQ-013 SHALL have port state, output, 3 bits: current FSM encoding, for debug.

Function
REQ-014 SHALL decode each 10-bit table entry as {type[1:0], payload[7:0]}: 00 CMD, 01 DATA, 10 DELAY (payload = ms), 11 END.
REQ-015 SHALL implement FSM states IDLE=0, HWRST=1, FETCH=2, SEND=3, DELAY=4, DONE=5, POSTRST=6.
REQ-016 SHALL, when start is high in IDLE or DONE, clear done, set busy and go to HWRST; the table index SHALL reset to 0.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL in FETCH read the entry at the current index and branch on its type: CMD/DATA to SEND, DELAY to DELAY, END to DONE; FETCH SHALL last exactly 1 cycle.
REQ-019 SHALL in SEND assert tx_valid, with tx_data = payload and tx_dc = type[0].
REQ-020 SHALL hold tx_valid, tx_data and tx_dc stable until a rising edge with tx_valid & tx_ready; on that edge it SHALL increment the index and return to FETCH.
REQ-021 SHALL in DELAY count payload ms ticks, where one ms tick = CLK_HZ/1000 clk cycles from a free prescaler restarted on DELAY entry.
REQ-022 SHALL, for a DELAY payload of 0, spend exactly 1 cycle in DELAY, then increment the index and go to FETCH.
REQ-023 SHALL treat index ROM_DEPTH-1 as END when its entry is not END, so the index never wraps.
REQ-024 SHALL in DONE deassert busy and assert done.
REQ-025 SHALL give a latency of exactly 2 cycles from the start edge to the first tx_valid when HWRST is compiled out and entry 0 is CMD.
REQ-026 SHALL keep tx_valid low in every state except SEND.

Reset
REQ-027 SHALL, on rst, immediately (asynchronously) set state=IDLE, index=0, tx_valid=0, tx_data=0, tx_dc=0, busy=0, done=0, tft_rst_n=1, and clear the prescaler and the ms counter.
REQ-028 SHALL, on reset mid-transfer, drop tx_valid without waiting for tx_ready.
REQ-029 SHALL not auto-start after reset; a start pulse is required.

Configuration
REQ-030 SHALL, with TFT_HW_RESET_EN defined, drive tft_rst_n=0 in HWRST for 10 ms, then drive tft_rst_n=1 in POSTRST for 120 ms, then go to FETCH.
REQ-031 SHALL, without TFT_HW_RESET_EN, tie tft_rst_n to 1, never enter HWRST or POSTRST, and go from start directly to FETCH.

Structure
REQ-032 SHALL place the state enum, the entry-type enum, the entry width (10) and the ms divisor function in package tft_pkg.
REQ-033 SHALL place the init table in sub-module tft_init_rom: combinational read, index in, 10-bit entry out, contents as a case table.
REQ-034 SHALL keep the prescaler and the ms counter inside tft_init_sequencer.

Verification (CLK_HZ=4000 so 1 ms = 4 cycles; test ROM = CMD 0x11, DELAY 2, CMD 0x29, DATA 0xA5, END)
REQ-035 SHALL cover: macro off, tx_ready tied 1, start -> bytes 0x11 (dc=0), 0x29 (dc=0), 0xA5 (dc=1) in order; the 0x11 to 0x29 gap includes 8 DELAY cycles; done=1, busy=0 afterwards.
REQ-036 SHALL cover: tx_ready held low 5 cycles during the 0x29 transfer -> tx_valid/tx_data stable for all 5 cycles; exactly one 0x29 transfer.
REQ-037 SHALL cover: start pulsed again mid-sequence -> no effect; total byte count remains 3.
REQ-038 SHALL cover: rst asserted while tx_valid=1 -> tx_valid=0 and state=0 before the next clk edge; a new start repeats the full sequence.
REQ-039 SHALL cover: macro on -> tft_rst_n low 40 cycles, then high 480 cycles before the first tx_valid.
REQ-040 SHALL cover: ROM filled with 32 CMD entries and no END -> 32 bytes sent, then DONE; the index does not wrap.
